ex_mem_stage_md: RTL and testbench
==================================

// Module: ex_mem_stage_md
// PURPOSE
//  Next-generation execute stage and EX/MEM pipeline register for the RISC-V core.
//  - Generalised to XLEN; drives forwarded operands out to the base ALU and registers its result.
//  - Adds valid tracking, flush, and an iterative RV32M multiply/divide unit (MD).
//  - MD requests an upstream stall while it works.
//  Sits between the ID/EX register and the MEM stage.
// PARAMETERS
//  XLEN   32  datapath width
//  MD_EN  1   1: M-extension ops go through MD unit; 0: every op takes the base-ALU path, busy tied 0
// PORTS
//  clk1          in   1     clock, rising edge
//  rst_n         in   1     asynchronous active-low reset
//  id_ex_valid   in   1     ID/EX holds a real instruction
//  id_ex_ir      in   32    instruction word
//  id_ex_type    in   3     instruction class from decode
//  id_ex_rs1     in   XLEN  register-file rs1 value
//  id_ex_rs2     in   XLEN  register-file rs2 value
//  mem_wb_aluout in   XLEN  MEM/WB forwarding source
//  ex_mem_fw     in   2     [1]: rs1 from EX/MEM, [0]: rs2 from EX/MEM
//  mem_wb_fw     in   2     [1]: rs1 from MEM/WB, [0]: rs2 from MEM/WB
//  op_a / op_b   out  XLEN  forwarded rs1 / rs2 to the base ALU (combinational)
//  alu_res       in   XLEN  base-ALU result (combinational, same cycle)
//  stall         in   1     downstream hold request
//  flush         in   1     kill the instruction in EX
//  ex_busy       out  1     MD unit busy; upstream must hold ID/EX
//  ex_mem_valid  out  1     EX/MEM holds a real instruction
//  ex_mem_ir     out  32    registered instruction word
//  ex_mem_type   out  3     registered instruction class
//  ex_mem_aluout out  XLEN  registered result
//  ex_mem_rs2    out  XLEN  registered forwarded rs2 (store data)
// BEHAVIOUR
//  Reset (async, rst_n=0): every EX/MEM output = 0, FSM = IDLE, ex_busy = 0, MD regs = 0.
//  Forwarding:
//   - op_a = ex_mem_fw[1] ? ex_mem_aluout : mem_wb_fw[1] ? mem_wb_aluout : id_ex_rs1.
//   - op_b is the same using bit [0]. EX/MEM has priority over MEM/WB.
//  MD op (md_op):
//   - Decoded when MD_EN=1, id_ex_ir[6:0]=0110011 and id_ex_ir[31:25]=0000001.
//   - funct3 selects: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
//  Base path (id_ex_valid and not md_op), on the rising edge:
//   - stall=0: EX/MEM <= {id_ex_valid, id_ex_ir, id_ex_type, alu_res, op_b}.
//   - stall=1: EX/MEM holds.
//  MD FSM, states IDLE -> BUSY -> DONE -> IDLE:
//   - IDLE with id_ex_valid & md_op: latch op_a, op_b, funct3, ir, type; cnt = 0; go to BUSY.
//     Forwarded operands are captured here because forwarding sources change while MD works.
//   - BUSY: one radix-2 step per cycle (shift-add multiply, restoring divide on magnitudes).
//     After XLEN steps go to DONE.
//   - DONE: apply sign fix-up. When stall=0, load EX/MEM with valid=1 and the MD result, then go to IDLE.
//     When stall=1, stay in DONE with the result held.
//   - ex_busy = (IDLE & id_ex_valid & md_op) | BUSY | (DONE & stall).
//   - While the FSM is not loading EX/MEM and stall=0, EX/MEM loads a bubble (valid=0, other fields held).
//   - Latency: an MD op seen in IDLE at edge 0 reaches EX/MEM at edge XLEN+2.
//   - After DONE->IDLE, ex_busy is low so the next ID/EX instruction advances.
//  MD results:
//   - MUL returns low XLEN bits; MULH*/MULHU return high XLEN bits. MULH is signed x signed, MULHSU is signed x unsigned.
//   - Divide by 0: DIV/DIVU quotient = all ones; REM/REMU = dividend.
//   - Signed overflow (-2^(XLEN-1) / -1): DIV = dividend, REM = 0.
//   - REM result takes the sign of the dividend.
//  Flush: synchronous, highest priority (above stall).
//   - EX/MEM valid <= 0; FSM <= IDLE; ex_busy = 0 in the flush cycle.
//  Simultaneous stall & flush: flush wins.
//  Reset mid-BUSY: immediate IDLE; no partial result is ever written.
// TESTING
//  1. rs1=5, ex_mem_aluout=0x10, mem_wb_aluout=0x20, both fw[1]=1 -> op_a=0x10; clear ex_mem_fw[1] -> op_a=0x20.
//  2. MUL 7 x -3 -> ex_busy high 33 cycles, ex_mem_valid=0 meanwhile, EX/MEM = 0xFFFFFFEB at edge 34.
//  3. DIV 100/0 -> 0xFFFFFFFF; REM 100%0 -> 100; DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
//  4. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0; DIV -7/2 -> -3, REM -> -1.
//  5. stall=1 held across DONE for 3 cycles -> result held, ex_busy=1; release -> loads once, valid=1 for one cycle.
//  6. flush at BUSY cycle 10 -> ex_busy=0 next cycle, valid=0; rst_n pulse mid-BUSY -> all outputs 0 at once.

Source files
------------

// File: rtl/ex_mem_stage_md.sv
// ex_mem_stage_md: execute stage with operand forwarding, iterative RV32M
// multiply/divide unit and the EX/MEM pipeline register.
//   clk1, rst_n                 clock (rising edge), asynchronous active-low reset
//   id_ex_*                     instruction, class and register operands from ID/EX
//   mem_wb_aluout               MEM/WB forwarding source
//   ex_mem_fw, mem_wb_fw        forwarding selects, [1] for rs1, [0] for rs2
//   op_a, op_b                  forwarded operands to the base ALU
//   alu_res                     base-ALU result for the current op_a/op_b
//   stall, flush                downstream hold, kill of the instruction in EX
//   ex_busy                     MD unit working; upstream holds ID/EX
//   ex_mem_*                    registered valid, instruction, class, result, store data
module ex_mem_stage_md #(
    parameter int XLEN  = 32,
    parameter bit MD_EN = 1'b1
) (
    input  logic            clk1,
    input  logic            rst_n,
    input  logic            id_ex_valid,
    input  logic [31:0]     id_ex_ir,
    input  logic [2:0]      id_ex_type,
    input  logic [XLEN-1:0] id_ex_rs1,
    input  logic [XLEN-1:0] id_ex_rs2,
    input  logic [XLEN-1:0] mem_wb_aluout,
    input  logic [1:0]      ex_mem_fw,
    input  logic [1:0]      mem_wb_fw,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    input  logic [XLEN-1:0] alu_res,
    input  logic            stall,
    input  logic            flush,
    output logic            ex_busy,
    output logic            ex_mem_valid,
    output logic [31:0]     ex_mem_ir,
    output logic [2:0]      ex_mem_type,
    output logic [XLEN-1:0] ex_mem_aluout,
    output logic [XLEN-1:0] ex_mem_rs2
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int CW = $clog2(XLEN);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] hi, lo, m, md_rs2;
    logic [31:0]     md_ir;
    logic [2:0]      md_type, f3;
    logic            sa, sb, bz;

    logic            md_op, start, sgn_a, sgn_b, neg_a, neg_b, div_ge;
    logic [XLEN-1:0] abs_a, abs_b, q_f, r_f, md_res;
    logic [XLEN:0]   mul_sum, div_sh, div_rem;
    logic [2*XLEN-1:0] prod_f;

    assign op_a = ex_mem_fw[1] ? ex_mem_aluout : mem_wb_fw[1] ? mem_wb_aluout : id_ex_rs1;
    assign op_b = ex_mem_fw[0] ? ex_mem_aluout : mem_wb_fw[0] ? mem_wb_aluout : id_ex_rs2;

    assign md_op   = MD_EN && id_ex_ir[6:0] == 7'b0110011 && id_ex_ir[31:25] == 7'b0000001;
    assign start   = state == IDLE && id_ex_valid && md_op;
    assign ex_busy = rst_n && !flush && (start || state == BUSY || (state == DONE && stall));

    // The core works on magnitudes; sa/sb remember which operands were negative
    // signed values so the result can be fixed up once the iterations finish.
    assign sgn_a = id_ex_ir[14:12] inside {3'd1, 3'd2, 3'd4, 3'd6};
    assign sgn_b = id_ex_ir[14:12] inside {3'd1, 3'd4, 3'd6};
    assign neg_a = sgn_a && op_a[XLEN-1];
    assign neg_b = sgn_b && op_b[XLEN-1];
    assign abs_a = neg_a ? -op_a : op_a;
    assign abs_b = neg_b ? -op_b : op_b;

    // Multiply: {hi,lo} shifts right, lo starts as the multiplier.
    // Divide: {hi,lo} shifts left, lo starts as the dividend and collects quotient bits.
    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    assign div_sh  = {hi, lo[XLEN-1]};
    assign div_ge  = div_sh >= {1'b0, m};
    assign div_rem = div_ge ? div_sh - {1'b0, m} : div_sh;

    // Divide by zero keeps the all-ones quotient unnegated; the overflow case
    // needs no special handling since the magnitude quotient wraps to the dividend.
    assign prod_f = (sa ^ sb) ? -{hi, lo} : {hi, lo};
    assign q_f    = (sa ^ sb && !bz) ? -lo : lo;
    assign r_f    = sa ? -hi : hi;
    assign md_res = f3 == 3'd0 ? prod_f[XLEN-1:0] : !f3[2] ? prod_f[2*XLEN-1:XLEN] : !f3[1] ? q_f : r_f;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            hi            <= '0;
            lo            <= '0;
            m             <= '0;
            md_rs2        <= '0;
            md_ir         <= '0;
            md_type       <= '0;
            f3            <= '0;
            sa            <= 1'b0;
            sb            <= 1'b0;
            bz            <= 1'b0;
            ex_mem_valid  <= 1'b0;
            ex_mem_ir     <= '0;
            ex_mem_type   <= '0;
            ex_mem_aluout <= '0;
            ex_mem_rs2    <= '0;
        end else if (flush) begin
            state        <= IDLE;
            ex_mem_valid <= 1'b0;
        end else begin
            if (start) begin
                state   <= BUSY;
                cnt     <= '0;
                hi      <= '0;
                lo      <= id_ex_ir[14] ? abs_a : abs_b;
                m       <= id_ex_ir[14] ? abs_b : abs_a;
                f3      <= id_ex_ir[14:12];
                sa      <= neg_a;
                sb      <= neg_b;
                bz      <= op_b == '0;
                md_ir   <= id_ex_ir;
                md_type <= id_ex_type;
                md_rs2  <= op_b;
            end else if (state == BUSY) begin
                cnt <= cnt + 1'b1;
                if (cnt == CW'(XLEN - 1))
                    state <= DONE;
                if (f3[2]) begin
                    hi <= div_rem[XLEN-1:0];
                    lo <= {lo[XLEN-2:0], div_ge};
                end else begin
                    hi <= mul_sum[XLEN:1];
                    lo <= {mul_sum[0], lo[XLEN-1:1]};
                end
            end else if (state == DONE && !stall) begin
                state <= IDLE;
            end
            if (!stall) begin
                if (state == DONE) begin
                    ex_mem_valid  <= 1'b1;
                    ex_mem_ir     <= md_ir;
                    ex_mem_type   <= md_type;
                    ex_mem_aluout <= md_res;
                    ex_mem_rs2    <= md_rs2;
                end else if (state == IDLE && id_ex_valid && !md_op) begin
                    ex_mem_valid  <= 1'b1;
                    ex_mem_ir     <= id_ex_ir;
                    ex_mem_type   <= id_ex_type;
                    ex_mem_aluout <= alu_res;
                    ex_mem_rs2    <= op_b;
                end else begin
                    ex_mem_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ex_mem_stage_md.sv
// tb_ex_mem_stage_md: randomized and directed bench for ex_mem_stage_md.
module tb_ex_mem_stage_md;
    localparam int XLEN = 32;

    logic            clk1 = 1'b0, rst_n = 1'b0;
    logic            id_ex_valid = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [31:0]     id_ex_ir = '0;
    logic [2:0]      id_ex_type = '0;
    logic [XLEN-1:0] id_ex_rs1 = '0, id_ex_rs2 = '0, mem_wb_aluout = '0, alu_res = '0;
    logic [1:0]      ex_mem_fw = '0, mem_wb_fw = '0;
    logic [XLEN-1:0] op_a, op_b, ex_mem_aluout, ex_mem_rs2;
    logic            ex_busy, ex_mem_valid;
    logic [31:0]     ex_mem_ir;
    logic [2:0]      ex_mem_type;

    int checks = 0, errors = 0;

    logic        m_valid = 1'b0;
    logic [31:0] m_ir = '0, m_alu = '0, m_rs2 = '0;
    logic [2:0]  m_type = '0;

    always #5 clk1 = ~clk1;

    ex_mem_stage_md #(.XLEN(XLEN), .MD_EN(1'b1)) dut (
        .clk1(clk1), .rst_n(rst_n), .id_ex_valid(id_ex_valid), .id_ex_ir(id_ex_ir),
        .id_ex_type(id_ex_type), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
        .mem_wb_aluout(mem_wb_aluout), .ex_mem_fw(ex_mem_fw), .mem_wb_fw(mem_wb_fw),
        .op_a(op_a), .op_b(op_b), .alu_res(alu_res), .stall(stall), .flush(flush),
        .ex_busy(ex_busy), .ex_mem_valid(ex_mem_valid), .ex_mem_ir(ex_mem_ir),
        .ex_mem_type(ex_mem_type), .ex_mem_aluout(ex_mem_aluout), .ex_mem_rs2(ex_mem_rs2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_valid"}, ex_mem_valid, m_valid);
        check({tag, "_ir"}, ex_mem_ir, m_ir);
        check({tag, "_type"}, ex_mem_type, m_type);
        check({tag, "_alu"}, ex_mem_aluout, m_alu);
        check({tag, "_rs2"}, ex_mem_rs2, m_rs2);
    endtask

    function automatic logic [31:0] md_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        logic ovf;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        p = '0;
        case (f3)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: r = b == 0 ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5: r = b == 0 ? 32'hFFFF_FFFF : a / b;
            3'd6: r = b == 0 ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: r = b == 0 ? a : a % b;
        endcase
        return r;
    endfunction

    // Called at a negedge; applies one cycle of base-path stimulus and checks the result.
    task automatic step_base(input logic v, input logic [31:0] ir, input logic [2:0] ty,
                             input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] wb,
                             input logic [31:0] al, input logic [1:0] efw, input logic [1:0] wfw,
                             input logic st, input logic fl);
        logic [31:0] ea, eb;
        id_ex_valid = v; id_ex_ir = ir; id_ex_type = ty; id_ex_rs1 = r1; id_ex_rs2 = r2;
        mem_wb_aluout = wb; alu_res = al; ex_mem_fw = efw; mem_wb_fw = wfw; stall = st; flush = fl;
        ea = efw[1] ? m_alu : wfw[1] ? wb : r1;
        eb = efw[0] ? m_alu : wfw[0] ? wb : r2;
        #1;
        check("op_a", op_a, ea);
        check("op_b", op_b, eb);
        check("base_busy", ex_busy, 0);
        if (fl) m_valid = 0;
        else if (!st) begin
            if (v) begin m_valid = 1; m_ir = ir; m_type = ty; m_alu = al; m_rs2 = eb; end
            else m_valid = 0;
        end
        @(negedge clk1);
        check_regs("base");
    endtask

    task automatic rand_base();
        step_base($urandom % 4 != 0, $urandom & 32'hFDFF_FFFF, 3'($urandom), $urandom, $urandom,
                  $urandom, $urandom, 2'($urandom), 2'($urandom), $urandom % 4 == 0, $urandom % 8 == 0);
        flush = 0;
    endtask

    // Issues one MD op at a negedge, holds stall for 'hold' cycles once the result is ready,
    // and checks busy duration, latency and result.
    task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int hold);
        int busy_n, load_edge;
        logic [31:0] ir;
        logic [2:0] ty;
        ir = {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
        ty = 3'($urandom);
        id_ex_valid = 1; id_ex_ir = ir; id_ex_type = ty; id_ex_rs1 = a; id_ex_rs2 = b;
        ex_mem_fw = 0; mem_wb_fw = 0; stall = 0; flush = 0; alu_res = $urandom;
        busy_n = 0;
        load_edge = -1;
        for (int k = 0; k < XLEN + hold + 6 && load_edge < 0; k++) begin
            stall = k >= XLEN + 1 && k < XLEN + 1 + hold;
            #1;
            if (ex_busy) busy_n++;
            else id_ex_valid = 0;
            @(negedge clk1);
            if (ex_mem_valid) load_edge = k + 1;
            else begin
                id_ex_rs1 = $urandom; id_ex_rs2 = $urandom; mem_wb_aluout = $urandom;
                ex_mem_fw = 2'($urandom); mem_wb_fw = 2'($urandom);
            end
        end
        stall = 0; id_ex_valid = 0; ex_mem_fw = 0; mem_wb_fw = 0;
        check("md_latency", load_edge, XLEN + 2 + hold);
        check("md_busy_cycles", busy_n, XLEN + 1 + hold);
        check("md_result", ex_mem_aluout, exp);
        check("md_ir", ex_mem_ir, ir);
        check("md_type", ex_mem_type, ty);
        m_valid = 0; m_ir = ir; m_type = ty; m_alu = exp; m_rs2 = b;
        @(negedge clk1);
        check_regs("md_after");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] f3;
        logic [31:0] a, b;
        logic seen;
        repeat (2) @(negedge clk1);
        check("rst_valid", ex_mem_valid, 0);
        check("rst_ir", ex_mem_ir, 0);
        check("rst_type", ex_mem_type, 0);
        check("rst_alu", ex_mem_aluout, 0);
        check("rst_rs2", ex_mem_rs2, 0);
        check("rst_busy", ex_busy, 0);
        rst_n = 1;

        step_base(1, 32'h0000_0013, 3'd3, 5, 7, 0, 32'h10, 0, 0, 0, 0);
        stall = 1; id_ex_valid = 0;
        id_ex_rs1 = 5; id_ex_rs2 = 9; mem_wb_aluout = 32'h20;
        ex_mem_fw = 2'b10; mem_wb_fw = 2'b11;
        #1 check("fw_ex_priority", op_a, 32'h10);
        ex_mem_fw = 2'b00;
        #1 check("fw_wb", op_a, 32'h20);
        ex_mem_fw = 2'b01; mem_wb_fw = 2'b00;
        #1 check("fw_none_a", op_a, 5);
        check("fw_ex_b", op_b, 32'h10);
        @(negedge clk1);
        check_regs("fw_hold");
        stall = 0;

        repeat (40) rand_base();

        run_md(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        run_md(3'd4, 32'd100, 32'd0, 32'hFFFF_FFFF, 0);
        run_md(3'd6, 32'd100, 32'd0, 32'd100, 0);
        run_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);
        run_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        run_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 0);
        run_md(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_md(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        run_md(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
        run_md(3'd5, 32'd100, 32'd7, 32'd14, 0);
        run_md(3'd7, 32'd100, 32'd7, 32'd2, 0);
        run_md(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 3);
        repeat (10) begin
            f3 = 3'($urandom);
            a = $urandom;
            b = ($urandom % 4 == 0) ? 32'h0 : $urandom;
            run_md(f3, a, b, md_ref(f3, a, b), $urandom % 3);
        end

        id_ex_valid = 1; id_ex_ir = {7'b0000001, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011};
        id_ex_rs1 = 5; id_ex_rs2 = 6; ex_mem_fw = 0; mem_wb_fw = 0; stall = 0;
        repeat (10) @(negedge clk1);
        check("flush_busy_before", ex_busy, 1);
        flush = 1;
        #1 check("flush_busy_now", ex_busy, 0);
        @(negedge clk1);
        flush = 0; id_ex_valid = 0; m_valid = 0;
        #1 check("flush_busy_after", ex_busy, 0);
        check_regs("flush");
        seen = 0;
        repeat (XLEN + 4) begin
            @(negedge clk1);
            if (ex_mem_valid) seen = 1;
        end
        check("flush_no_result", seen, 0);

        step_base(1, 32'h00A0_0293, 3'd5, 1, 2, 3, 32'hDEAD_BEEF, 0, 0, 0, 0);
        id_ex_valid = 1; id_ex_ir = {7'b0000001, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011};
        id_ex_rs1 = 5; id_ex_rs2 = 6;
        repeat (10) @(negedge clk1);
        rst_n = 0;
        #1;
        check("rmid_valid", ex_mem_valid, 0);
        check("rmid_ir", ex_mem_ir, 0);
        check("rmid_type", ex_mem_type, 0);
        check("rmid_alu", ex_mem_aluout, 0);
        check("rmid_rs2", ex_mem_rs2, 0);
        check("rmid_busy", ex_busy, 0);
        @(negedge clk1);
        id_ex_valid = 0; rst_n = 1;
        m_valid = 0; m_ir = 0; m_type = 0; m_alu = 0; m_rs2 = 0;
        seen = 0;
        repeat (XLEN + 4) begin
            @(negedge clk1);
            if (ex_mem_valid) seen = 1;
        end
        check("rst_no_result", seen, 0);
        check_regs("post_rst");

        repeat (20) rand_base();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
